// File: rtl/freq_gate_counter.sv
`timescale 1ns/1ps
// freq_gate_counter
//   Gated edge counter for the frequency meter. Runs a fixed-length gate
//   window, counts synchronised rising edges of sig_in inside it, latches the
//   count at the end of the gate, then idles for a short gap so the ISR can
//   read the result before the next gate begins.
// Ports
//   clk        in   1          system clock
//   reset      in   1          asynchronous active-high reset
//   enable     in   1          level; 1 = run gates back to back
//   sig_in     in   1          measured signal, asynchronous to clk
//   freq_en    out  1          registered; 1 while in GATE
//   count_out  out  CNT_WIDTH  edge count latched from last completed gate
//   overflow   out  1          1 = last gate's count saturated
//   meas_done  out  1          1-cycle pulse on the cycle count_out updates
module freq_gate_counter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES  = 1000,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic                 freq_en,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 overflow,
  output logic                 meas_done
);

  localparam int unsigned TMAX = (GATE_CYCLES > GAP_CYCLES) ? GATE_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]        GATE_LOAD = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0]        GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GATE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic [CNT_WIDTH-1:0]   r_edge_cnt;
  logic                   r_ovf;
  logic [TW-1:0]          r_timer;

  logic                   w_rise;
  logic                   w_sat;
  logic [CNT_WIDTH-1:0]   w_cnt_next;
  logic                   w_ovf_next;

  // Synchroniser chain plus one delay flop for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  // Saturating next count; used both for the running count and for the latch
  // so an edge seen in the final gate cycle still lands in count_out
  always_comb begin
    w_rise     = r_sync[SYNC_STAGES-1] & ~r_dly;
    w_sat      = (r_edge_cnt == CNT_MAX);
    w_cnt_next = (w_rise && !w_sat) ? r_edge_cnt + CNT_WIDTH'(1) : r_edge_cnt;
    w_ovf_next = r_ovf | (w_rise & w_sat);
  end

  // Gate sequencer: IDLE -> GATE -> GAP -> (GATE | IDLE)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
      r_timer    <= '0;
      freq_en    <= 1'b0;
      count_out  <= '0;
      overflow   <= 1'b0;
      meas_done  <= 1'b0;
    end else begin
      meas_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          freq_en <= 1'b0;
          if (enable) begin
            r_state    <= S_GATE;
            freq_en    <= 1'b1;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
            r_timer    <= GATE_LOAD;
          end
        end
        S_GATE: begin
          r_edge_cnt <= w_cnt_next;
          r_ovf      <= w_ovf_next;
          if (r_timer == '0) begin
            r_state   <= S_GAP;
            freq_en   <= 1'b0;
            count_out <= w_cnt_next;
            overflow  <= w_ovf_next;
            meas_done <= 1'b1;
            r_timer   <= GAP_LOAD;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_GAP: begin
          // enable is only looked at here, so a gate is never truncated
          if (r_timer == '0) begin
            if (enable) begin
              r_state    <= S_GATE;
              freq_en    <= 1'b1;
              r_edge_cnt <= '0;
              r_ovf      <= 1'b0;
              r_timer    <= GATE_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          freq_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
`timescale 1ns/1ps
// Bench for freq_gate_counter: two instances (32-bit and 4-bit counters) share
// stimulus; expected counts come from counting rising transitions of the
// recorded sig_in history inside each gate's detection window.
module tb_freq_gate_counter;

  localparam int GATE = 100;
  localparam int GAP  = 10;
  localparam int SYNC = 2;
  localparam int LAG  = SYNC + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sig_in;
  logic        fe32, ov32, md32;
  logic [31:0] cnt32;
  logic        fe4, ov4, md4;
  logic [3:0]  cnt4;

  freq_gate_counter #(.GATE_CYCLES(GATE), .GAP_CYCLES(GAP), .CNT_WIDTH(32), .SYNC_STAGES(SYNC)) dut32 (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq_en(fe32), .count_out(cnt32), .overflow(ov32), .meas_done(md32));

  freq_gate_counter #(.GATE_CYCLES(GATE), .GAP_CYCLES(GAP), .CNT_WIDTH(4), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq_en(fe4), .count_out(cnt4), .overflow(ov4), .meas_done(md4));

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   hist [0:8191];

  // stimulus pattern: 0 low, 1 high, 2 periodic, 3 random, 4 step up at pat_x
  int   pat_mode = 0;
  int   pat_p    = 10;
  int   pat_x    = 0;

  logic        exp_fe, exp_md;
  logic [31:0] exp_cnt32, exp_cnt4;
  logic        exp_ov32, exp_ov4;

  function automatic logic pat_val(input int c);
    case (pat_mode)
      1:       return 1'b1;
      2:       return ((c % pat_p) < (pat_p / 2)) ? 1'b1 : 1'b0;
      3:       return 1'($urandom_range(0, 1));
      4:       return (c >= pat_x) ? 1'b1 : 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("freq_en32",   32'(fe32),  32'(exp_fe));
    chk("meas_done32", 32'(md32),  32'(exp_md));
    chk("count32",     cnt32,      exp_cnt32);
    chk("overflow32",  32'(ov32),  32'(exp_ov32));
    chk("freq_en4",    32'(fe4),   32'(exp_fe));
    chk("meas_done4",  32'(md4),   32'(exp_md));
    chk("count4",      32'(cnt4),  exp_cnt4);
    chk("overflow4",   32'(ov4),   32'(exp_ov4));
  endtask

  // advance one clock; drive sig_in for the new cycle and record it
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    sig_in    = pat_val(cyc);
    hist[cyc] = sig_in;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      exp_fe = 1'b0;
      exp_md = 1'b0;
      check_all();
    end
  endtask

  // expected result of a gate entered at edge s: rises driven in cycle c are
  // seen by the counter at edge c+LAG, and the gate counts edges s+1..s+GATE
  task automatic latch_expect(input int s);
    int n = 0;
    for (int c = s + 1 - LAG; c <= s + GATE - LAG; c++)
      if (hist[c] && !hist[c-1]) n++;
    exp_cnt32 = 32'(n);
    exp_ov32  = 1'b0;
    exp_cnt4  = (n > 15) ? 32'd15 : 32'(n);
    exp_ov4   = (n > 15);
  endtask

  // called with cyc == s-1; runs the whole gate and its gap
  task automatic run_gate(input int s, input int drop_off);
    while (cyc < s + GATE + GAP - 1) begin
      tick();
      if (drop_off >= 0 && cyc == s + drop_off) enable = 1'b0;
      exp_fe = (cyc >= s && cyc < s + GATE);
      exp_md = (cyc == s + GATE);
      if (cyc == s + GATE) latch_expect(s);
      check_all();
    end
  endtask

  initial begin
    int s;
    reset = 1'b1; enable = 1'b0; sig_in = 1'b0;
    exp_fe = 1'b0; exp_md = 1'b0;
    exp_cnt32 = '0; exp_cnt4 = '0; exp_ov32 = 1'b0; exp_ov4 = 1'b0;
    for (int i = 0; i < 8192; i++) hist[i] = 1'b0;

    // reset state
    idle_steps(3);
    reset = 1'b0;
    idle_steps(5);

    // period 10 -> 10 edges per gate, back to back
    pat_mode = 2; pat_p = 10;
    enable = 1'b1;
    run_gate(cyc + 1, -1);
    run_gate(cyc + 1, -1);

    // period 2 -> 50 edges; 4-bit copy saturates
    pat_p = 2;
    run_gate(cyc + 1, -1);
    run_gate(cyc + 1, -1);

    // period 4 -> 25 edges, then recovery with period 10
    pat_p = 4;
    run_gate(cyc + 1, -1);
    pat_p = 10;
    run_gate(cyc + 1, -1);

    // random activity
    pat_mode = 3;
    run_gate(cyc + 1, -1);
    run_gate(cyc + 1, -1);

    // held high, held low
    pat_mode = 1;
    run_gate(cyc + 1, -1);
    pat_mode = 0;
    run_gate(cyc + 1, -1);

    // single rise detected on the last gate cycle is counted
    s = cyc + 1;
    pat_mode = 4; pat_x = s + GATE - LAG;
    run_gate(s, -1);

    // single rise one cycle later is detected in GAP and ignored
    pat_mode = 0;
    idle_steps(0);
    s = cyc + 1;
    run_gate(s, -1);
    s = cyc + 1;
    pat_mode = 4; pat_x = s + GATE - LAG + 1;
    run_gate(s, -1);
    pat_mode = 1;
    run_gate(cyc + 1, -1);

    // enable dropped mid-gate: gate completes, then stays idle
    pat_mode = 2; pat_p = 10;
    run_gate(cyc + 1, 40);
    idle_steps(30);

    // reset in mid-gate: immediate clear, no meas_done, clean restart
    enable = 1'b1;
    s = cyc + 1;
    while (cyc < s + 50) begin
      tick();
      exp_fe = (cyc >= s);
      exp_md = 1'b0;
      check_all();
    end
    pat_mode = 0;
    reset = 1'b1;
    #1;
    exp_fe = 1'b0; exp_md = 1'b0;
    exp_cnt32 = '0; exp_cnt4 = '0; exp_ov32 = 1'b0; exp_ov4 = 1'b0;
    check_all();
    idle_steps(3);
    reset = 1'b0;
    pat_mode = 2; pat_p = 10;
    run_gate(cyc + 1, 60);
    idle_steps(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
